// File: rtl/booth_seq_multiplier_pkg.sv
// mult_pkg: shared types and helpers for the radix-4 Booth sequential multiplier.
//   state_t       : controller states IDLE / BUSY / DONE
//   booth_digit_t : decoded Booth digit as {neg, one, two} selects
//   booth_decode  : maps a multiplier triplet {b[2i+1], b[2i], b[2i-1]} to a digit
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;  // digit is negative
    logic one;  // |digit| == 1
    logic two;  // |digit| == 2
  } booth_digit_t;

  // 000/111 -> 0, 001/010 -> +1, 011 -> +2, 100 -> -2, 101/110 -> -1.
  // neg is suppressed for 111 so a zero digit is always encoded as all-zero.
  function automatic booth_digit_t booth_decode(input logic [2:0] t);
    booth_digit_t d;
    d.neg = t[2] & ~(t[1] & t[0]);
    d.one = t[1] ^ t[0];
    d.two = (t == 3'b011) || (t == 3'b100);
    return d;
  endfunction

endpackage

// File: rtl/booth_seq_multiplier_if.sv
// Operand/result handshake bundle for booth_seq_multiplier.
//   src_valid/src_ready   : operand handshake (a, b, a_signed, b_signed)
//   dest_valid/dest_ready : product handshake (prod)
//   busy                  : multiplier is iterating
// master = producer/consumer side, slave = multiplier side.
interface booth_seq_multiplier_if #(
  parameter int WIDTH = 16
);
  logic                   src_valid;
  logic                   src_ready;
  logic [WIDTH-1:0]       a;
  logic [WIDTH-1:0]       b;
  logic                   a_signed;
  logic                   b_signed;
  logic                   dest_valid;
  logic                   dest_ready;
  logic [2*WIDTH-1:0]     prod;
  logic                   busy;

  modport master (
    output src_valid, a, b, a_signed, b_signed, dest_ready,
    input  src_ready, dest_valid, prod, busy
  );

  modport slave (
    input  src_valid, a, b, a_signed, b_signed, dest_ready,
    output src_ready, dest_valid, prod, busy
  );
endinterface

// File: rtl/booth_seq_multiplier_pp_gen.sv
// booth_r4_pp_gen: combinational radix-4 Booth partial-product generator.
//   a_ext : (WIDTH+2)-bit sign/zero-extended multiplicand
//   digit : decoded Booth digit
//   pp    : signed (WIDTH+4)-bit digit * a_ext
// The extra two bits keep -2*a_ext exact for the most-negative multiplicand.
module booth_r4_pp_gen
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic signed [WIDTH+1:0] a_ext,
  input  booth_digit_t            digit,
  output logic signed [WIDTH+3:0] pp
);

  logic signed [WIDTH+3:0] a_wide;
  logic signed [WIDTH+3:0] mag;

  always_comb begin
    a_wide = {{2{a_ext[WIDTH+1]}}, a_ext};
    mag    = '0;
    if (digit.one)
      mag = a_wide;
    else if (digit.two)
      mag = a_wide <<< 1;
    pp = digit.neg ? -mag : mag;
  end

endmodule

// File: rtl/booth_seq_multiplier.sv
// booth_seq_multiplier: sequential radix-4 Booth multiplier, one digit per clock.
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of booth_seq_multiplier_if (operand and product handshakes)
// Operands are extended to WIDTH+2 bits per their mode bits, so one signed
// datapath covers every signed/unsigned combination. The product is exact in
// 2*WIDTH bits; dest_valid rises ITER edges after the accepting edge.
module booth_seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input logic                  clk,
  input logic                  rst,
  booth_seq_multiplier_if.slave bus
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;        // extended operand width
  localparam int PW   = WIDTH + 4;        // partial product width
  localparam int AW   = 2 * WIDTH + 4;    // accumulator width
  localparam int CW   = $clog2(ITER + 1);

  if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_width_chk
    $error("booth_seq_multiplier: WIDTH must be even and >= 4");
  end

  state_t                state;
  logic signed [XW-1:0]  a_ext;
  logic [XW:0]           mq;              // {b_ext, b_ext[-1]=0}, shifted right 2 per step
  logic signed [AW-1:0]  acc;
  logic [CW-1:0]         cnt;
  logic [2*WIDTH-1:0]    prod_r;
  logic                  dest_valid_r;

  booth_digit_t          digit;
  logic signed [PW-1:0]  pp;
  logic signed [AW-1:0]  acc_nxt;

  assign digit = booth_decode(mq[2:0]);

  booth_r4_pp_gen #(.WIDTH(WIDTH)) u_pp_gen (
    .a_ext (a_ext),
    .digit (digit),
    .pp    (pp)
  );

  // Shift-then-add at bit WIDTH: digit i ends up weighted by 4^i after the
  // remaining ITER-1-i shifts, so no low-order bit is ever shifted out.
  assign acc_nxt = (acc >>> 2) + $signed({pp, {WIDTH{1'b0}}});

  assign bus.src_ready  = (state == IDLE);
  assign bus.busy       = (state == BUSY);
  assign bus.dest_valid = dest_valid_r;
  assign bus.prod       = prod_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      a_ext        <= '0;
      mq           <= '0;
      acc          <= '0;
      cnt          <= '0;
      prod_r       <= '0;
      dest_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.src_valid) begin
            a_ext <= {{2{bus.a_signed & bus.a[WIDTH-1]}}, bus.a};
            mq    <= {{2{bus.b_signed & bus.b[WIDTH-1]}}, bus.b, 1'b0};
            acc   <= '0;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          acc <= acc_nxt;
          mq  <= mq >> 2;
          cnt <= cnt + 1'b1;
          // Load the result from the final step directly so prod appears
          // on the ITER-th edge rather than one edge later.
          if (cnt == CW'(ITER - 1)) begin
            prod_r       <= acc_nxt[2*WIDTH-1:0];
            dest_valid_r <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          if (bus.dest_ready) begin
            dest_valid_r <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
